// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter, one power-of-two shift per register stage.
// Logical/arithmetic shifts and rotates, global stall on back-pressure.
module pipelined_barrel_shifter #(
   parameter int WIDTH = 32,
   parameter int SAW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d,
   input  logic [SAW-1:0]   sa,
   input  logic             right,
   input  logic             arith,
   input  logic             rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sh,
   output logic             z
);

   function automatic logic [WIDTH-1:0] step(
      input logic [WIDTH-1:0] x,
      input int               k,
      input logic             take,
      input logic             r,
      input logic             a,
      input logic             ro,
      input logic             s
   );
      logic [2*WIDTH-1:0] ext;
      logic [WIDTH-1:0]   fill;
      fill = (a && s) ? '1 : '0;
      if (!take) return x;
      if (r) begin
         ext = {ro ? x : fill, x} >> (1 << k);
         return ext[WIDTH-1:0];
      end
      ext = {x, ro ? x : {WIDTH{1'b0}}} << (1 << k);
      return ext[2*WIDTH-1:WIDTH];
   endfunction

   logic             en;
   logic [SAW-1:0]   vld;
   logic [WIDTH-1:0] dat [SAW];
   logic [WIDTH-1:0] nxt [SAW];
   logic [SAW-1:0]   sam [SAW-1];
   logic [SAW-2:0]   rgt;
   logic [SAW-2:0]   ari;
   logic [SAW-2:0]   rtt;
   logic [SAW-2:0]   sgn;

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out_valid = vld[SAW-1];
   assign sh        = dat[SAW-1];

   // sgn carries the input MSB so later stages fill with the true sign
   always_comb begin
      nxt[0] = step(d, 0, sa[0], right, arith, rot, d[WIDTH-1]);
      for (int k = 1; k < SAW; k++)
         nxt[k] = step(dat[k-1], k, sam[k-1][0], rgt[k-1],
                       ari[k-1], rtt[k-1], sgn[k-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         rgt <= '0;
         ari <= '0;
         rtt <= '0;
         sgn <= '0;
         z   <= 1'b0;
         for (int k = 0; k < SAW; k++)
            dat[k] <= '0;
         for (int k = 0; k < SAW - 1; k++)
            sam[k] <= '0;
      end else if (en) begin
         vld <= {vld[SAW-2:0], in_valid};
         rgt <= {rgt[SAW-3:0], right};
         ari <= {ari[SAW-3:0], arith};
         rtt <= {rtt[SAW-3:0], rot};
         sgn <= {sgn[SAW-3:0], d[WIDTH-1]};
         // sa bits are consumed from the bottom, one per stage
         sam[0] <= sa >> 1;
         for (int k = 1; k < SAW - 1; k++)
            sam[k] <= sam[k-1] >> 1;
         for (int k = 0; k < SAW; k++)
            dat[k] <= nxt[k];
         z <= (nxt[SAW-1] == '0);
      end
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: vector table, scoreboard,
// back-pressure, throughput, reset-in-flight and an 8-bit instance.
module tb_pipelined_barrel_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, right, arith, rot;
   logic        out_valid, out_ready, z;
   logic [31:0] d, sh;
   logic [4:0]  sa;

   logic        b_in_valid, b_in_ready, b_right, b_arith, b_rot;
   logic        b_out_valid, b_out_ready, b_z;
   logic [7:0]  b_d, b_sh;
   logic [2:0]  b_sa;

   pipelined_barrel_shifter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .d(d), .sa(sa), .right(right), .arith(arith), .rot(rot),
      .out_valid(out_valid), .out_ready(out_ready), .sh(sh), .z(z)
   );

   pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .d(b_d), .sa(b_sa), .right(b_right), .arith(b_arith), .rot(b_rot),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .sh(b_sh), .z(b_z)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] sh;
      logic        z;
      int          acc;
      logic        lat;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  sa;
      logic        r, a, ro;
      logic [31:0] esh;
      logic        ez;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic [2:0] sa;
      logic       r, a, ro;
      logic [7:0] esh;
   } v8_t;

   exp_t sb[$];
   vec_t vt[15];
   v8_t  v8[5];
   int   tests = 0, fails = 0;
   int   pops = 0, stray = 0, streak = 0, best = 0;
   logic taken;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] x,
      input logic [4:0] s, input logic r, input logic a, input logic ro);
      int n;
      n = int'(s);
      if (ro && r) return (x >> n) | (x << (32 - n));
      if (ro) return (x << n) | (x >> (32 - n));
      if (r && a) return $signed(x) >>> n;
      if (r) return x >> n;
      return x << n;
   endfunction

   task automatic cycle(input logic [31:0] esh, input logic ez,
                        input logic lat);
      exp_t e;
      #1;
      if (out_valid) begin
         streak++;
         if (streak > best) best = streak;
      end else begin
         streak = 0;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            stray++;
         end else begin
            e = sb.pop_front();
            pops++;
            chk("sh", sh, e.sh);
            chk("z", 32'(z), 32'(e.z));
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd5);
         end
      end
      taken = in_valid && in_ready;
      if (taken) sb.push_back('{esh, ez, cyc, lat});
      @(negedge clk);
   endtask

   task automatic drain();
      int k;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         cycle(32'h0, 1'b0, 1'b0);
         k++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic drive(input logic [31:0] x, input logic [4:0] s,
                        input logic r, input logic a, input logic ro);
      in_valid = 1'b1;
      d = x;
      sa = s;
      right = r;
      arith = a;
      rot = ro;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ex, held;
      logic [31:0] bd[8];
      logic [4:0]  bs[8];
      logic [2:0]  bm[8];
      int i, t, k, n, stalls;

      vt[0]  = '{32'hFF0000FF, 5'd8,  1'b0, 1'b0, 1'b0, 32'h0000FF00, 1'b0};
      vt[1]  = '{32'hFF0000FF, 5'd8,  1'b1, 1'b0, 1'b0, 32'h00FF0000, 1'b0};
      vt[2]  = '{32'hFF0000FF, 5'd8,  1'b1, 1'b1, 1'b0, 32'hFFFF0000, 1'b0};
      vt[3]  = '{32'hFF0000FF, 5'd8,  1'b0, 1'b0, 1'b1, 32'h0000FFFF, 1'b0};
      vt[4]  = '{32'hFF0000FF, 5'd8,  1'b1, 1'b0, 1'b1, 32'hFFFF0000, 1'b0};
      vt[5]  = '{32'hFF0000FF, 5'd8,  1'b0, 1'b1, 1'b0, 32'h0000FF00, 1'b0};
      vt[6]  = '{32'hFF0000FF, 5'd8,  1'b1, 1'b1, 1'b1, 32'hFFFF0000, 1'b0};
      vt[7]  = '{32'h80000000, 5'd31, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b0};
      vt[8]  = '{32'h80000000, 5'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1};
      vt[9]  = '{32'h80000000, 5'd31, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
      vt[10] = '{32'h12345678, 5'd0,  1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0};
      vt[11] = '{32'h12345678, 5'd0,  1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0};
      vt[12] = '{32'h12345678, 5'd0,  1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0};
      vt[13] = '{32'h12345678, 5'd0,  1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0};
      vt[14] = '{32'h12345678, 5'd0,  1'b1, 1'b0, 1'b1, 32'h12345678, 1'b0};

      v8[0] = '{8'hF1, 3'd4, 1'b1, 1'b1, 1'b0, 8'hFF};
      v8[1] = '{8'hF1, 3'd4, 1'b0, 1'b0, 1'b1, 8'h1F};
      v8[2] = '{8'hF1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h10};
      v8[3] = '{8'hF1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h0F};
      v8[4] = '{8'hF1, 3'd4, 1'b1, 1'b0, 1'b1, 8'h1F};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1;
      d = '0; sa = '0; right = 1'b0; arith = 1'b0; rot = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      b_d = '0; b_sa = '0; b_right = 1'b0; b_arith = 1'b0; b_rot = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sh", sh, 32'd0);
      chk("rst_z", 32'(z), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // vector table, one at a time with latency
      for (int v = 0; v < 15; v++) begin
         drive(vt[v].d, vt[v].sa, vt[v].r, vt[v].a, vt[v].ro);
         cycle(vt[v].esh, vt[v].ez, 1'b1);
         chk($sformatf("vec%0d_accept", v), 32'(taken), 32'd1);
         drain();
      end

      // throughput: 16 back-to-back
      best = 0; streak = 0; n = 0;
      for (int j = 0; j < 16; j++) begin
         drive($urandom, 5'($urandom_range(0, 31)), 1'($urandom),
               1'($urandom), 1'($urandom));
         ex = model(d, sa, right, arith, rot);
         cycle(ex, ex == 0, 1'b1);
         if (taken) n++;
      end
      drain();
      chk("thru_accepted", 32'(n), 32'd16);
      chk("thru_streak", 32'(best), 32'd16);

      // back-pressure: 4 stall cycles mid-stream
      for (int j = 0; j < 8; j++) begin
         bd[j] = $urandom;
         bs[j] = 5'($urandom_range(1, 31));
         bm[j] = 3'($urandom);
      end
      pops = 0; i = 0; t = 0; stalls = 0; held = '0;
      while ((i < 8 || sb.size() != 0) && t < 80) begin
         out_ready = !(t >= 7 && t < 11);
         if (i < 8) drive(bd[i], bs[i], bm[i][0], bm[i][1], bm[i][2]);
         else in_valid = 1'b0;
         ex = model(d, sa, right, arith, rot);
         #1;
         if (!out_ready && out_valid && sb.size() != 0) begin
            stalls++;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_sh", sh, sb[0].sh);
            if (t == 7) held = sh;
            else chk("stall_hold", sh, held);
         end
         cycle(ex, ex == 0, 1'b0);
         if (taken) i++;
         t++;
      end
      drain();
      chk("bp_stalls", 32'(stalls), 32'd4);
      chk("bp_count", 32'(pops), 32'd8);

      // reset with operations in flight
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         drive(32'h0F0F_0001 + 32'(j), 5'd4, 1'b0, 1'b0, 1'b1);
         ex = model(d, sa, right, arith, rot);
         cycle(ex, 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 10) begin
         cycle(32'h0, 1'b0, 1'b0);
         k++;
      end
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      if (sb.size() != 0) chk("pre_rst_sh", sh, sb[0].sh);
      #2 rst = 1'b1;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_sh", sh, 32'd0);
      chk("async_z", 32'(z), 32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      stray = 0;
      repeat (10) cycle(32'h0, 1'b0, 1'b0);
      chk("no_stale", 32'(stray), 32'd0);
      drive(32'hFF0000FF, 5'd8, 1'b0, 1'b0, 1'b1);
      cycle(32'h0000FFFF, 1'b0, 1'b1);
      drain();

      // 8-bit instance, latency 3
      for (int v = 0; v < 5; v++) begin
         b_in_valid = 1'b1;
         b_d = v8[v].d; b_sa = v8[v].sa;
         b_right = v8[v].r; b_arith = v8[v].a; b_rot = v8[v].ro;
         #1;
         chk($sformatf("w8_%0d_ready", v), 32'(b_in_ready), 32'd1);
         n = cyc;
         @(negedge clk);
         b_in_valid = 1'b0;
         k = 0;
         while (!b_out_valid && k < 10) begin
            @(negedge clk);
            k++;
         end
         chk($sformatf("w8_%0d_valid", v), 32'(b_out_valid), 32'd1);
         chk($sformatf("w8_%0d_lat", v), 32'(cyc - n), 32'd3);
         chk($sformatf("w8_%0d_sh", v), 32'(b_sh), 32'(v8[v].esh));
         chk($sformatf("w8_%0d_z", v), 32'(b_z), 32'(v8[v].esh == 0));
         @(negedge clk);
      end

      chk("stray_outputs", 32'(stray), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
